// File: rtl/hs32_fetch_q.sv
// hs32 instruction prefetch queue: sequential fetch with one outstanding request,
// power-of-two {pc, data} FIFO toward decode, and flush/redirect with stale-word drop.
module hs32_fetch_q #(
  parameter int            DEPTH    = 4,
  parameter int            PBITS    = 2,
  parameter int            AW       = 32,
  parameter int            DW       = 32,
  parameter logic [AW-1:0] RESET_PC = '0,
  parameter logic [AW-1:0] PC_STEP  = AW'(4)
) (
  input  logic          clk,
  input  logic          rstn,
  output logic [AW-1:0] addr,
  input  logic [DW-1:0] dtr,
  output logic          reqm,
  input  logic          ackm,
  output logic [DW-1:0] instd,
  output logic [AW-1:0] instd_pc,
  input  logic          reqd,
  output logic          ackd,
  input  logic [AW-1:0] newpc,
  input  logic          flush,
  output logic [PBITS:0] level
);

  localparam logic [PBITS:0] DEPTH_L = (PBITS+1)'(DEPTH);
  localparam logic [PBITS:0] PTR_ONE = (PBITS+1)'(1);

  logic [AW-1:0]  pc_q, pc_d;
  logic [AW-1:0]  addr_q, addr_d;
  logic           reqm_q, reqm_d;
  logic           drop_q, drop_d;
  logic [PBITS:0] wp_q, wp_d;
  logic [PBITS:0] rp_q, rp_d;
  logic [PBITS:0] lvl, lvl_nxt;
  logic           push, pop;

  logic [AW-1:0]  fifo_pc_q  [DEPTH];
  logic [DW-1:0]  fifo_dat_q [DEPTH];

  assign lvl  = wp_q - rp_q;
  assign ackd = (lvl != '0);
  assign pop  = reqd && ackd;
  // A word returning for a request that a flush has orphaned never enters the FIFO.
  assign push = ackm && reqm_q && !drop_q && !flush;

  always_comb begin
    pc_d    = pc_q;
    addr_d  = addr_q;
    reqm_d  = reqm_q;
    drop_d  = drop_q;
    wp_d    = wp_q;
    rp_d    = rp_q;
    lvl_nxt = lvl;
    if (flush) begin
      wp_d = rp_q;
      pc_d = newpc;
      if (reqm_q && !ackm) begin
        drop_d = 1'b1;
      end else if (reqm_q) begin
        reqm_d = 1'b0;
        drop_d = 1'b0;
      end else begin
        reqm_d = 1'b1;
        addr_d = newpc;
        drop_d = 1'b0;
      end
    end else begin
      if (push) begin
        wp_d = wp_q + PTR_ONE;
        pc_d = pc_q + PC_STEP;
      end
      if (pop) rp_d = rp_q + PTR_ONE;
      lvl_nxt = wp_d - rp_d;
      // Issue (or re-issue back-to-back on completion) only when a slot will be free.
      if (!reqm_q || ackm) begin
        reqm_d = (lvl_nxt < DEPTH_L);
        addr_d = pc_d;
        drop_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pc_q   <= RESET_PC;
      addr_q <= RESET_PC;
      reqm_q <= 1'b0;
      drop_q <= 1'b0;
      wp_q   <= '0;
      rp_q   <= '0;
    end else begin
      pc_q   <= pc_d;
      addr_q <= addr_d;
      reqm_q <= reqm_d;
      drop_q <= drop_d;
      wp_q   <= wp_d;
      rp_q   <= rp_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_pc_q[wp_q[PBITS-1:0]]  <= addr_q;
      fifo_dat_q[wp_q[PBITS-1:0]] <= dtr;
    end
  end

  assign addr     = addr_q;
  assign reqm     = reqm_q;
  assign level    = lvl;
  assign instd    = fifo_dat_q[rp_q[PBITS-1:0]];
  assign instd_pc = fifo_pc_q[rp_q[PBITS-1:0]];

endmodule

// File: tb/tb_hs32_fetch_q.sv
// Directed bench for hs32_fetch_q: default 4-deep/32-bit instance plus an
// 8-deep/24-bit instance that exercises pointer and pc wrap.
module tb_hs32_fetch_q;

  logic        clk;
  logic        rstn, ackm, reqd, flush;
  logic [31:0] dtr, newpc, addr, instd, instd_pc;
  logic        reqm, ackd;
  logic [2:0]  level;

  logic        rstn_b, ackm_b, reqd_b, flush_b;
  logic [31:0] dtr_b, instd_b;
  logic [23:0] newpc_b, addr_b, instd_pc_b;
  logic        reqm_b, ackd_b;
  logic [3:0]  level_b;

  int n_tests = 0;
  int n_fail  = 0;

  hs32_fetch_q #(.DEPTH(4), .PBITS(2), .AW(32), .DW(32),
                 .RESET_PC(32'h100), .PC_STEP(32'd4)) u_dut (
    .clk(clk), .rstn(rstn), .addr(addr), .dtr(dtr), .reqm(reqm), .ackm(ackm),
    .instd(instd), .instd_pc(instd_pc), .reqd(reqd), .ackd(ackd),
    .newpc(newpc), .flush(flush), .level(level));

  hs32_fetch_q #(.DEPTH(8), .PBITS(3), .AW(24), .DW(32),
                 .RESET_PC(24'hFFFFE0), .PC_STEP(24'd4)) u_dut8 (
    .clk(clk), .rstn(rstn_b), .addr(addr_b), .dtr(dtr_b), .reqm(reqm_b), .ackm(ackm_b),
    .instd(instd_b), .instd_pc(instd_pc_b), .reqd(reqd_b), .ackd(ackd_b),
    .newpc(newpc_b), .flush(flush_b), .level(level_b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] exp_pc;
    logic [23:0] exp_pc_b;
    rstn = 1'b0; ackm = 1'b0; reqd = 1'b0; flush = 1'b0; dtr = '0; newpc = '0;
    rstn_b = 1'b0; ackm_b = 1'b0; reqd_b = 1'b0; flush_b = 1'b0; dtr_b = '0; newpc_b = '0;
    step(); step();
    check("rst_reqm", reqm, 0);
    check("rst_level", level, 0);
    check("rst_ackd", ackd, 0);
    check("rst_addr", addr, 32'h100);

    // reset and fill
    rstn = 1'b1;
    step();
    for (int i = 0; i < 4; i++) begin
      check("fill_reqm", reqm, 1);
      check("fill_addr", addr, 32'h100 + 32'(4 * i));
      dtr  = 32'hD000_0000 | addr;
      ackm = 1'b1;
      step();
    end
    ackm = 1'b0;
    check("full_level", level, 4);
    check("full_reqm", reqm, 0);
    check("full_ackd", ackd, 1);
    check("full_head_pc", instd_pc, 32'h100);
    check("full_head_dat", instd, 32'hD000_0100);
    step(); step();
    check("full_hold_reqm", reqm, 0);
    check("full_hold_level", level, 4);

    // one pop while full frees a slot
    reqd = 1'b1;
    step();
    reqd = 1'b0;
    check("pop_level", level, 3);
    check("pop_reqm", reqm, 1);
    check("pop_addr", addr, 32'h110);
    check("pop_head", instd_pc, 32'h104);

    // coincident push and pop
    dtr = 32'hD000_0000 | addr; ackm = 1'b1; reqd = 1'b1;
    step();
    ackm = 1'b0; reqd = 1'b0;
    check("pp_level", level, 3);
    check("pp_head", instd_pc, 32'h108);
    check("pp_addr", addr, 32'h114);

    // streaming with zero-wait arbiter
    exp_pc = 32'h108;
    for (int i = 0; i < 8; i++) begin
      check("str_head_pc", instd_pc, exp_pc);
      check("str_head_dat", instd, 32'hD000_0000 | exp_pc);
      check("str_level", level, 3);
      reqd = 1'b1;
      ackm = reqm;
      dtr  = 32'hD000_0000 | addr;
      step();
      exp_pc = exp_pc + 32'd4;
    end
    reqd = 1'b0; ackm = 1'b0;
    check("str_end_head", instd_pc, 32'h128);
    check("str_end_addr", addr, 32'h134);

    // flush coincident with ackm and reqd at level 2
    reqd = 1'b1;
    step();
    check("f5_pre_level", level, 2);
    check("f5_pre_head", instd_pc, 32'h12C);
    flush = 1'b1; newpc = 32'h3000; ackm = 1'b1; reqd = 1'b1; dtr = 32'h1234_5678;
    step();
    flush = 1'b0; ackm = 1'b0; reqd = 1'b0;
    check("f5_level", level, 0);
    check("f5_ackd", ackd, 0);
    check("f5_reqm", reqm, 0);
    step();
    check("f5_next_reqm", reqm, 1);
    check("f5_next_addr", addr, 32'h3000);
    check("f5_next_level", level, 0);

    // flush while a request is outstanding
    ackm = 1'b1; dtr = 32'hD000_3000;
    step();
    dtr = 32'hD000_3004;
    step();
    ackm = 1'b0;
    check("f4_pre_level", level, 2);
    check("f4_pre_addr", addr, 32'h3008);
    flush = 1'b1; newpc = 32'h2000;
    step();
    flush = 1'b0;
    check("f4_level", level, 0);
    check("f4_ackd0", ackd, 0);
    check("f4_hold_reqm", reqm, 1);
    check("f4_hold_addr", addr, 32'h3008);
    step();
    check("f4_ackd1", ackd, 0);
    step();
    check("f4_ackd2", ackd, 0);
    check("f4_hold_addr2", addr, 32'h3008);
    ackm = 1'b1; dtr = 32'hDEAD_BEEF;
    step();
    ackm = 1'b0;
    check("f4_drop_ackd", ackd, 0);
    check("f4_drop_level", level, 0);
    check("f4_new_reqm", reqm, 1);
    check("f4_new_addr", addr, 32'h2000);
    ackm = 1'b1; dtr = 32'hD000_2000;
    step();
    ackm = 1'b0;
    check("f4_new_ackd", ackd, 1);
    check("f4_new_head_pc", instd_pc, 32'h2000);
    check("f4_new_head_dat", instd, 32'hD000_2000);

    // async reset mid-operation
    ackm = 1'b1; dtr = 32'hD000_2004;
    step();
    dtr = 32'hD000_2008;
    step();
    ackm = 1'b0;
    check("ar_pre_level", level, 3);
    check("ar_pre_reqm", reqm, 1);
    #2 rstn = 1'b0;
    #1;
    check("ar_reqm", reqm, 0);
    check("ar_level", level, 0);
    check("ar_ackd", ackd, 0);
    check("ar_addr", addr, 32'h100);
    @(posedge clk);
    #1 rstn = 1'b1;
    step();
    check("ar_restart_reqm", reqm, 1);
    check("ar_restart_addr", addr, 32'h100);

    // 8-deep, 24-bit instance: fill then stream across pointer and pc wrap
    rstn_b = 1'b1;
    step();
    check("b_first_addr", addr_b, 24'hFFFFE0);
    for (int i = 0; i < 8; i++) begin
      ackm_b = reqm_b;
      dtr_b  = 32'hB000_0000 | {8'h00, addr_b};
      step();
    end
    ackm_b = 1'b0;
    check("b_full_level", level_b, 8);
    check("b_full_reqm", reqm_b, 0);
    check("b_full_head", instd_pc_b, 24'hFFFFE0);
    exp_pc_b = 24'hFFFFE0;
    for (int i = 0; i < 24; i++) begin
      check("b_str_head_pc", instd_pc_b, exp_pc_b);
      check("b_str_head_dat", instd_b, 32'hB000_0000 | {8'h00, exp_pc_b});
      check("b_str_level_ok", level_b <= 4'd8, 1);
      reqd_b = 1'b1;
      ackm_b = reqm_b;
      dtr_b  = 32'hB000_0000 | {8'h00, addr_b};
      step();
      exp_pc_b = exp_pc_b + 24'd4;
    end
    reqd_b = 1'b0; ackm_b = 1'b0;
    check("b_end_head", instd_pc_b, 24'h000040);
    check("b_end_level", level_b, 7);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
